// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int          WORD_W       = 64;
  localparam int          MASK_W       = 8;
  localparam logic [63:0] DEFAULT_BASE = 64'h0000_0000_8000_0000;
endpackage

// File: rtl/mem_array.sv
// Word-wide storage with one synchronous read/write port and byte-lane write mask.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [MASK_W-1:0] i_wmask,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  // Read data only moves on a read access, so it stays stable while a response is held.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < MASK_W; i++)
          if (i_wmask[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one outstanding request, in-order, with range check.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = DEFAULT_BASE,
  parameter int          LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [63:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_write;
  logic [63:0]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic              r_err, r_rd_ok;

  logic              w_accept, w_access, w_write, w_in_range;
  logic [63:0]       w_addr, w_off;
  logic [WORD_W-1:0] w_wdata, w_arr_rdata;
  logic [MASK_W-1:0] w_wmask;

  assign w_accept = (r_state == IDLE) && req_valid;
  // With LATENCY=1 the access happens on the accept edge, straight from the request inputs.
  assign w_access = ((r_state == BUSY) && (r_cnt == '0)) || (w_accept && (LATENCY == 1));

  assign w_write = (r_state == IDLE) ? req_write : r_write;
  assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_wmask = (r_state == IDLE) ? req_wmask : r_wmask;

  // Offset compare avoids computing BASE+size, which could wrap at the top of the space.
  assign w_off      = w_addr - BASE_ADDR;
  assign w_in_range = (w_addr >= BASE_ADDR) && ((w_off >> 3) < 64'(DEPTH_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (r_cnt == '0) w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CW'(LATENCY - 1);
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wmask <= req_wmask;
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_access) begin
        r_err   <= ~w_in_range;
        r_rd_ok <= w_in_range & ~w_write;
      end
    end
  end

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk     (clk),
    .i_en    (w_access & w_in_range),
    .i_we    (w_write),
    .i_idx   (w_off[AW+2:3]),
    .i_wdata (w_wdata),
    .i_wmask (w_wmask),
    .o_rdata (w_arr_rdata)
  );

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rd_ok ? w_arr_rdata : '0;
  assign rsp_err   = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder (LATENCY=3, DEPTH_WORDS=1024).
module tb_mem_responder;
  localparam int          LAT   = 3;
  localparam int          DEPTH = 1024;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [63:0] mdl [int];

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(8 * DEPTH));
  endfunction

  // Called at a negedge; drives one request and checks its response through the scoreboard.
  task automatic xact(input string tag, input logic w, input logic [63:0] a,
                      input logic [63:0] d, input logic [7:0] m, input int hold);
    exp_t        e, got;
    int          k, idx;
    logic [63:0] old;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    e.err   = !in_rng(a);
    e.rdata = '0;
    if (!e.err) begin
      idx = int'((a - BASE) >> 3);
      if (w) begin
        old = mdl.exists(idx) ? mdl[idx] : 64'h0;
        for (int i = 0; i < 8; i++) if (m[i]) old[8*i +: 8] = d[8*i +: 8];
        if (m != 8'h00 || mdl.exists(idx)) mdl[idx] = old;
      end else begin
        e.rdata = mdl[idx];
      end
    end
    sb.push_back(e);
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
    chk({tag, "_latency"}, 64'(k), 64'(LAT));
    for (int h = 0; h < hold; h++) begin
      chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a;
      req_wdata = 64'hDEAD_BEEF_DEAD_BEEF; req_wmask = 8'hFF;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      got = sb.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, got.rdata);
      chk({tag, "_err"}, 64'(rsp_err), 64'(got.err));
    end
    @(negedge clk);
    chk({tag, "_bubble_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_rsp_dropped"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    xact("wr_full", 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0);
    xact("rd_full", 1'b0, 64'h8000_0010, '0, 8'h00, 0);
    xact("wr_part", 1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0);
    xact("rd_part", 1'b0, 64'h8000_0010, '0, 8'h00, 0);
    chk("model_part", mdl[2], 64'h1122_3344_AAAA_AAAA);
    xact("rd_unalig", 1'b0, 64'h8000_0013, '0, 8'h00, 0);
    xact("rd_below", 1'b0, 64'h7FFF_FFF8, '0, 8'h00, 0);
    xact("rd_above", 1'b0, BASE + 64'(8 * DEPTH), '0, 8'h00, 0);

    xact("wr_w0", 1'b1, 64'h8000_0000, 64'h0101_0202_0303_0404, 8'hFF, 0);
    xact("wr_wlast", 1'b1, 64'h8000_1FF8, 64'hF0F0_E1E1_D2D2_C3C3, 8'hFF, 0);
    xact("wr_oor", 1'b1, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    xact("rd_w0", 1'b0, 64'h8000_0000, '0, 8'h00, 0);
    xact("rd_wlast", 1'b0, 64'h8000_1FF8, '0, 8'h00, 0);

    xact("bp_rd", 1'b0, 64'h8000_0010, '0, 8'h00, 5);
    xact("bp_after", 1'b0, 64'h8000_0010, '0, 8'h00, 0);

    xact("wr_nomask", 1'b1, 64'h8000_0010, 64'h0, 8'h00, 0);
    xact("rd_nomask", 1'b0, 64'h8000_0010, '0, 8'h00, 0);

    // Mid-BUSY reset: the write must not reach the array.
    xact("wr_pre", 1'b1, 64'h8000_0018, 64'h5555_6666_7777_8888, 8'hFF, 0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h8000_0018;
    req_wdata = 64'h0BAD_0BAD_0BAD_0BAD; req_wmask = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_busy", 64'(req_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstmid_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    chk("rstmid_no_rsp", 64'(rsp_valid), 64'd0);
    xact("rd_post_rst", 1'b0, 64'h8000_0018, '0, 8'h00, 0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
